// File: rtl/relprime_result_checker.sv
// relprime_result_checker: verifies m is the smallest integer >= 2
// coprime to n, using subtractive Euclid (no divider).
module relprime_result_checker #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
  output logic [WIDTH-1:0] bad_k
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK_IN,
    S_LOAD,
    S_GCD,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BAD_IN  = 2'd1;
  localparam logic [1:0] ERR_NOT_CP  = 2'd2;
  localparam logic [1:0] ERR_NOT_MIN = 2'd3;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_t           state;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Checker FSM: candidate walk k=2..m, one gcd per candidate.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_code <= ERR_OK;
      bad_k    <= '0;
      n        <= '0;
      m        <= '0;
      k        <= '0;
      a        <= '0;
      b        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n        <= n_in;
            m        <= m_in;
            pass     <= 1'b0;
            err_code <= ERR_OK;
            bad_k    <= '0;
            busy     <= 1'b1;
            state    <= S_CHECK_IN;
          end
        end
        S_CHECK_IN: begin
          if (n < TWO || m < TWO) begin
            err_code <= ERR_BAD_IN;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            k     <= TWO;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          a     <= n;
          b     <= k;
          state <= S_GCD;
        end
        S_GCD: begin
          if (a > b) begin
            a <= a - b;
          end else if (b > a) begin
            b <= b - a;
          end else begin
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (k < m && a == ONE) begin
            err_code <= ERR_NOT_MIN;
            bad_k    <= k;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (k == m && a != ONE) begin
            err_code <= ERR_NOT_CP;
            bad_k    <= k;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (k == m) begin
            pass     <= 1'b1;
            err_code <= ERR_OK;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            k     <= k + ONE;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relprime_result_checker.sv
// tb_relprime_result_checker: directed and randomized verdict checks
// against a modulo-Euclid reference and a cycle-count model.
module tb_relprime_result_checker;

  localparam int W     = 16;
  localparam int LIMIT = 40000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] n_in;
  logic [W-1:0] m_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [1:0]   err_code;
  logic [W-1:0] bad_k;

  int n_checks;
  int n_fail;

  relprime_result_checker #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .start    (start),
    .n_in     (n_in),
    .m_in     (m_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_code (err_code),
    .bad_k    (bad_k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_mod(input int x, input int y);
    int p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic int smallest_cp(input int n);
    int k;
    k = 2;
    while (gcd_mod(n, k) != 1) k++;
    return k;
  endfunction

  // verdict: {pass, err, bad_k}
  task automatic ref_verdict(input int n, input int m,
                             output int e_pass, output int e_err,
                             output int e_bad);
    e_pass = 0;
    e_err  = 0;
    e_bad  = 0;
    if (n < 2 || m < 2) begin
      e_err = 1;
    end else begin
      for (int k = 2; k <= m; k++) begin
        if (k < m && gcd_mod(n, k) == 1) begin
          e_err = 3;
          e_bad = k;
          break;
        end
        if (k == m) begin
          if (gcd_mod(n, k) != 1) begin
            e_err = 2;
            e_bad = k;
          end else begin
            e_pass = 1;
          end
        end
      end
    end
  endtask

  // edges from the accepting edge up to the one that raises done
  function automatic int ref_latency(input int n, input int m);
    int lat, a, b, g;
    if (n < 2 || m < 2) return 2;
    lat = 2;
    for (int k = 2; k <= m; k++) begin
      a = n;
      b = k;
      g = 0;
      forever begin
        g++;
        if (a == b) break;
        if (a > b) a = a - b;
        else b = b - a;
      end
      lat += 2 + g;
      if (k == m || a == 1) break;
    end
    return lat;
  endfunction

  task automatic run(input string tag, input int n, input int m,
                     input bit chk_lat, input int inj);
    int  lat, e_pass, e_err, e_bad;
    bit  both;
    ref_verdict(n, m, e_pass, e_err, e_bad);
    @(negedge clk);
    start = 1'b1;
    n_in  = W'(n);
    m_in  = W'(m);
    @(posedge clk);
    #1;
    start = 1'b0;
    n_in  = '0;
    m_in  = '0;
    lat   = 1;
    both  = 1'b0;
    check({tag, ".busy_rise"}, busy, 1);
    while (!done && lat < LIMIT) begin
      if (lat == inj) begin
        @(negedge clk);
        start = 1'b1;
        n_in  = W'(9);
        m_in  = W'(2);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      both |= busy & done;
    end
    check({tag, ".timeout"}, 32'(lat >= LIMIT), 0);
    check({tag, ".busy_done_excl"}, 32'(both), 0);
    check({tag, ".pass"}, pass, e_pass);
    check({tag, ".err_code"}, err_code, e_err);
    check({tag, ".bad_k"}, bad_k, e_bad);
    if (chk_lat) check({tag, ".latency"}, lat, ref_latency(n, m));
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int rn, rm;
    bit saw_done;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    start    = 1'b0;
    n_in     = '0;
    m_in     = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.err", err_code, 0);
    check("rst.bad_k", bad_k, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("n1000_m3", 1000, 3, 1'b1, 0);
    check("n1000_m3.lat_const", ref_latency(1000, 3), 842);
    run("n1000_m7", 1000, 7, 1'b0, 0);
    run("n1000_m2", 1000, 2, 1'b1, 0);
    run("n6_m5", 6, 5, 1'b1, 0);
    run("n1_m3", 1, 3, 1'b1, 0);
    run("n5_m1", 5, 1, 1'b1, 0);
    run("ignore_start", 1000, 3, 1'b1, 4);
    run("n9_m2", 9, 2, 1'b1, 0);

    // asynchronous reset in the middle of a long gcd
    @(negedge clk);
    start = 1'b1;
    n_in  = 16'hFFFF;
    m_in  = W'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("mid.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid.busy", busy, 0);
    check("mid.done", done, 0);
    check("mid.pass", pass, 0);
    check("mid.err", err_code, 0);
    check("mid.bad_k", bad_k, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      saw_done |= done | busy;
    end
    check("mid.quiet", 32'(saw_done), 0);
    run("n65535_m2", 65535, 2, 1'b1, 0);

    for (int i = 0; i < 4; i++) begin
      rn = int'($urandom_range(2000, 2));
      rm = smallest_cp(rn);
      run($sformatf("rnd%0d_min", i), rn, rm, 1'b1, 0);
      run($sformatf("rnd%0d_plus", i), rn, rm + 1, 1'b0, 0);
      run($sformatf("rnd%0d_minus", i), rn, rm - 1, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
